// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter sharing one single-port, fixed-latency data memory.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: requester 1 always wins ties (no round-robin).
module dmem_port_arbiter #(
    parameter int AW      = 14,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [AW-1:0]   req0_addr,
    input  logic            req0_we,
    input  logic [DW/8-1:0] req0_wmask,
    input  logic [DW-1:0]   req0_wdata,
    output logic            rsp0_valid,
    output logic [DW-1:0]   rsp0_rdata,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [AW-1:0]   req1_addr,
    input  logic            req1_we,
    input  logic [DW/8-1:0] req1_wmask,
    input  logic [DW-1:0]   req1_wdata,
    output logic            rsp1_valid,
    output logic [DW-1:0]   rsp1_rdata,
    output logic            mem_en,
    output logic [DW/8-1:0] mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int MW = DW / 8;
    localparam int CW = 2;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;
    logic            grant_r;
    logic            grant_s;
    logic            we_r;
    logic            we_s;
    logic            win_s;
    logic            accept_s;
    logic            accept_ok_s;
    logic            sel_we_s;
    logic [MW-1:0]   sel_mask_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_wdata_s;
    logic            rsp_fire_s;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic            rr_last_r;
`endif

    // Winner selection among the valid requesters.
    always_comb begin
        win_s = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        if (req1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`else
        if (req0_valid && req1_valid) begin
            win_s = ~rr_last_r;
        end else if (req1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`endif
    end

    // Payload mux from the current winner.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_mask_s  = {MW{1'b0}};
        sel_addr_s  = {AW{1'b0}};
        sel_wdata_s = {DW{1'b0}};
        if (win_s) begin
            sel_we_s    = req1_we;
            sel_mask_s  = req1_wmask;
            sel_addr_s  = req1_addr;
            sel_wdata_s = req1_wdata;
        end else begin
            sel_we_s    = req0_we;
            sel_mask_s  = req0_wmask;
            sel_addr_s  = req0_addr;
            sel_wdata_s = req0_wdata;
        end
    end

    // Next-state logic; the counter holds at zero on the BUSY exit so it never wraps.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        grant_s  = grant_r;
        we_s     = we_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept_s = 1'b1;
                    grant_s  = win_s;
                    we_s     = sel_we_s;
                    cnt_s    = CNT_LOAD;
                    state_s  = ST_BUSY;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Handshake and memory strobes are suppressed while reset is held.
    assign accept_ok_s = accept_s & rst_n;
    assign req0_ready  = accept_ok_s & ~win_s;
    assign req1_ready  = accept_ok_s & win_s;
    assign mem_en      = accept_ok_s;
    assign mem_we      = (accept_ok_s && sel_we_s) ? sel_mask_s : {MW{1'b0}};
    assign mem_addr    = accept_ok_s ? sel_addr_s : {AW{1'b0}};
    assign mem_wdata   = accept_ok_s ? sel_wdata_s : {DW{1'b0}};

    assign rsp_fire_s  = (state_r == ST_BUSY) && (cnt_r == {CW{1'b0}});
    assign rsp0_valid  = rsp_fire_s & ~grant_r;
    assign rsp1_valid  = rsp_fire_s & grant_r;
    assign rsp0_rdata  = (rsp0_valid && !we_r) ? mem_rdata : {DW{1'b0}};
    assign rsp1_rdata  = (rsp1_valid && !we_r) ? mem_rdata : {DW{1'b0}};

    // Transaction state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            grant_r <= 1'b0;
            we_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            grant_r <= grant_s;
            we_r    <= we_s;
        end
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Round-robin history; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_r <= 1'b1;
        end else if (accept_s) begin
            rr_last_r <= win_s;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench: instance a runs MEM_LAT=1, instance b runs MEM_LAT=3.
module tb_dmem_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    exp_t a_q[$];
    exp_t b_q[$];

    logic a_rst_n, a_req0_valid, a_req0_ready, a_req0_we, a_rsp0_valid;
    logic a_req1_valid, a_req1_ready, a_req1_we, a_rsp1_valid, a_mem_en;
    logic [AW-1:0] a_req0_addr, a_req1_addr, a_mem_addr;
    logic [3:0] a_req0_wmask, a_req1_wmask, a_mem_we;
    logic [31:0] a_req0_wdata, a_req1_wdata, a_rsp0_rdata, a_rsp1_rdata, a_mem_wdata, a_mem_rdata;

    logic b_rst_n, b_req0_valid, b_req0_ready, b_req0_we, b_rsp0_valid;
    logic b_req1_valid, b_req1_ready, b_req1_we, b_rsp1_valid, b_mem_en;
    logic [AW-1:0] b_req0_addr, b_req1_addr, b_mem_addr;
    logic [3:0] b_req0_wmask, b_req1_wmask, b_mem_we;
    logic [31:0] b_req0_wdata, b_req1_wdata, b_rsp0_rdata, b_rsp1_rdata, b_mem_wdata, b_mem_rdata;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_addr(a_req0_addr),
        .req0_we(a_req0_we), .req0_wmask(a_req0_wmask), .req0_wdata(a_req0_wdata),
        .rsp0_valid(a_rsp0_valid), .rsp0_rdata(a_rsp0_rdata),
        .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_addr(a_req1_addr),
        .req1_we(a_req1_we), .req1_wmask(a_req1_wmask), .req1_wdata(a_req1_wdata),
        .rsp1_valid(a_rsp1_valid), .rsp1_rdata(a_rsp1_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_addr(b_req0_addr),
        .req0_we(b_req0_we), .req0_wmask(b_req0_wmask), .req0_wdata(b_req0_wdata),
        .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_addr(b_req1_addr),
        .req1_we(b_req1_we), .req1_wmask(b_req1_wmask), .req1_wdata(b_req1_wdata),
        .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Memory models: preloaded while reset is low, word i = 0xC0DE00ii.
    logic [31:0] a_mem [0:255];
    logic [31:0] a_pipe;
    logic [31:0] b_mem [0:255];
    logic [31:0] b_p0, b_p1, b_p2;

    always @(posedge clk) begin
        if (!a_rst_n) begin
            for (int i = 0; i < 256; i++) a_mem[i] <= {24'hC0DE00, 8'(i)};
            a_mem[4]  <= 32'hDEADBEEF;
            a_mem[16] <= 32'hAAAAAAAA;
        end else if (a_mem_en) begin
            a_pipe <= a_mem[a_mem_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (a_mem_we[b]) a_mem[a_mem_addr[7:0]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
        end
    end
    assign a_mem_rdata = a_pipe;

    always @(posedge clk) begin
        if (!b_rst_n) begin
            for (int i = 0; i < 256; i++) b_mem[i] <= {24'hC0DE00, 8'(i)};
        end else if (b_mem_en) begin
            b_p0 <= b_mem[b_mem_addr[7:0]];
        end
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign b_mem_rdata = b_p2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor for instance a: pops the scoreboard on every response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (a_rst_n === 1'b1) begin
            if (!a_rsp0_valid) check("a rsp0_rdata idle", a_rsp0_rdata, 32'h0);
            if (!a_rsp1_valid) check("a rsp1_rdata idle", a_rsp1_rdata, 32'h0);
            if (a_rsp0_valid || a_rsp1_valid) begin
                check("a single rsp", {31'h0, a_rsp0_valid & a_rsp1_valid}, 32'h0);
                if (a_q.size() == 0) begin
                    fail_now("a unexpected rsp");
                end else begin
                    e = a_q.pop_front();
                    check("a rsp port", {31'h0, a_rsp1_valid}, {31'h0, e.port});
                    check("a rsp data", e.port ? a_rsp1_rdata : a_rsp0_rdata, e.data);
                end
            end
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        exp_t e;
        if (b_rst_n === 1'b1) begin
            if (!b_rsp0_valid) check("b rsp0_rdata idle", b_rsp0_rdata, 32'h0);
            if (!b_rsp1_valid) check("b rsp1_rdata idle", b_rsp1_rdata, 32'h0);
            if (b_rsp0_valid || b_rsp1_valid) begin
                check("b single rsp", {31'h0, b_rsp0_valid & b_rsp1_valid}, 32'h0);
                if (b_q.size() == 0) begin
                    fail_now("b unexpected rsp");
                end else begin
                    e = b_q.pop_front();
                    check("b rsp port", {31'h0, b_rsp1_valid}, {31'h0, e.port});
                    check("b rsp data", e.port ? b_rsp1_rdata : b_rsp0_rdata, e.data);
                end
            end
        end
    end

    task automatic a_drop();
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    endtask

    task automatic a_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                         input logic [3:0] mask, input logic [31:0] wdata, input logic [31:0] exp_rd);
        bit got;
        exp_t e;
        @(posedge clk); #1;
        if (port) begin
            a_req1_valid = 1'b1; a_req1_we = we; a_req1_addr = addr; a_req1_wmask = mask; a_req1_wdata = wdata;
        end else begin
            a_req0_valid = 1'b1; a_req0_we = we; a_req0_addr = addr; a_req0_wmask = mask; a_req0_wdata = wdata;
        end
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (port ? a_req1_ready : a_req0_ready) got = 1'b1;
        end
        if (!got) begin
            fail_now("txn accept timeout");
            a_drop();
        end else begin
            check("txn other ready", {31'h0, port ? a_req0_ready : a_req1_ready}, 32'h0);
            check("txn mem_en", {31'h0, a_mem_en}, 32'h1);
            check("txn mem_addr", {18'h0, a_mem_addr}, {18'h0, addr});
            check("txn mem_we", {28'h0, a_mem_we}, we ? {28'h0, mask} : 32'h0);
            if (we) check("txn mem_wdata", a_mem_wdata, wdata);
            e.port = port; e.data = exp_rd;
            a_q.push_back(e);
            @(posedge clk); #1;
            a_drop();
            @(negedge clk);
            check("txn rsp latency", {31'h0, port ? a_rsp1_valid : a_rsp0_valid}, 32'h1);
            check("txn busy mem_en", {31'h0, a_mem_en}, 32'h0);
            check("txn busy mem_we", {28'h0, a_mem_we}, 32'h0);
        end
    endtask

    task automatic seq_a();
        bit got;
        logic exp_port;
        exp_t e;
        a_rst_n = 1'b0;
        a_req0_valid = 1'b1; a_req0_we = 1'b0; a_req0_addr = '0; a_req0_wmask = '0; a_req0_wdata = '0;
        a_req1_valid = 1'b0; a_req1_we = 1'b0; a_req1_addr = '0; a_req1_wmask = '0; a_req1_wdata = '0;
        repeat (3) begin
            @(negedge clk);
            check("a reset ready0", {31'h0, a_req0_ready}, 32'h0);
            check("a reset mem_en", {31'h0, a_mem_en}, 32'h0);
            check("a reset mem_we", {28'h0, a_mem_we}, 32'h0);
            check("a reset rsp0", {31'h0, a_rsp0_valid}, 32'h0);
            check("a reset rdata0", a_rsp0_rdata, 32'h0);
        end
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        a_drop();

        // Both requesters held valid with fixed payloads across four grants.
        @(posedge clk); #1;
        a_req0_valid = 1'b1; a_req0_addr = 14'h0020; a_req0_we = 1'b0;
        a_req1_valid = 1'b1; a_req1_addr = 14'h0021; a_req1_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_port = FIXED ? (k == 3 ? 1'b0 : 1'b1) : k[0];
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                if (a_req0_ready || a_req1_ready) got = 1'b1;
            end
            if (!got) begin
                fail_now("tie accept timeout");
            end else begin
                check("tie grant", {31'h0, a_req1_ready}, {31'h0, exp_port});
                check("tie one ready", {31'h0, a_req0_ready & a_req1_ready}, 32'h0);
                check("tie mem_addr", {18'h0, a_mem_addr}, exp_port ? 32'h21 : 32'h20);
                e.port = exp_port; e.data = exp_port ? 32'hC0DE0021 : 32'hC0DE0020;
                a_q.push_back(e);
                @(negedge clk);
                check("tie busy ready", {30'h0, a_req0_ready, a_req1_ready}, 32'h0);
                check("tie busy mem_en", {31'h0, a_mem_en}, 32'h0);
                if (FIXED && k == 2) a_req1_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        a_drop();

        a_txn(1'b0, 1'b0, 14'h0004, 4'h0, 32'h0, 32'hDEADBEEF);
        a_txn(1'b1, 1'b1, 14'h0010, 4'b0110, 32'h11223344, 32'h0);
        a_txn(1'b1, 1'b0, 14'h0010, 4'h0, 32'h0, 32'hAA2233AA);
        a_txn(1'b0, 1'b1, 14'h0030, 4'b1111, 32'h5A5A5A5A, 32'h0);
        a_txn(1'b0, 1'b0, 14'h0030, 4'h0, 32'h0, 32'h5A5A5A5A);
        a_txn(1'b1, 1'b1, 14'h0031, 4'b1001, 32'hFFEEDDCC, 32'h0);
        a_txn(1'b0, 1'b0, 14'h0031, 4'h0, 32'h0, 32'hFFDE00CC);
    endtask

    task automatic seq_b();
        exp_t e;
        b_rst_n = 1'b0;
        b_req0_valid = 1'b0; b_req0_we = 1'b0; b_req0_addr = '0; b_req0_wmask = '0; b_req0_wdata = '0;
        b_req1_valid = 1'b0; b_req1_we = 1'b0; b_req1_addr = '0; b_req1_wmask = '0; b_req1_wdata = '0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        b_rst_n = 1'b1;

        // Continuous requester 0 traffic: accepts every 4th cycle, responses 3 later.
        @(posedge clk); #1;
        b_req0_valid = 1'b1; b_req0_addr = 14'h0008;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("thr accept", {31'h0, b_req0_ready}, {31'h0, (c % 4) == 0});
            check("thr rsp", {31'h0, b_rsp0_valid}, {31'h0, (c % 4) == 3});
            if ((c % 4) == 0) begin
                e.port = 1'b0; e.data = 32'hC0DE0008;
                b_q.push_back(e);
            end
        end
        b_req0_valid = 1'b0;

        // Accept, then reset in the next cycle: the transaction vanishes.
        @(posedge clk); #1;
        b_req0_valid = 1'b1; b_req0_addr = 14'h0009;
        @(negedge clk);
        check("rst accept", {31'h0, b_req0_ready}, 32'h1);
        @(posedge clk); #1;
        b_rst_n = 1'b0;
        b_req0_addr = 14'h0020;
        b_req1_valid = 1'b1; b_req1_addr = 14'h0021;
        repeat (4) begin
            @(negedge clk);
            check("rst ready0", {31'h0, b_req0_ready}, 32'h0);
            check("rst ready1", {31'h0, b_req1_ready}, 32'h0);
            check("rst mem_en", {31'h0, b_mem_en}, 32'h0);
            check("rst mem_we", {28'h0, b_mem_we}, 32'h0);
            check("rst rsp0", {31'h0, b_rsp0_valid}, 32'h0);
            check("rst rsp1", {31'h0, b_rsp1_valid}, 32'h0);
            check("rst rdata0", b_rsp0_rdata, 32'h0);
            check("rst rdata1", b_rsp1_rdata, 32'h0);
        end
        b_rst_n = 1'b1;
        #1;
        check("rst first tie r1", {31'h0, b_req1_ready}, {31'h0, FIXED});
        check("rst first tie r0", {31'h0, b_req0_ready}, {31'h0, !FIXED});
        e.port = FIXED; e.data = FIXED ? 32'hC0DE0021 : 32'hC0DE0020;
        b_q.push_back(e);
        @(posedge clk); #1;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        fork
            seq_a();
            seq_b();
        join
        repeat (4) @(negedge clk);
        check("a scoreboard drained", a_q.size(), 32'h0);
        check("b scoreboard drained", b_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
